// File: rtl/ws2812b_pkg.sv
// Shared WS2812b timing helpers and receiver state encoding.
// Driver and receiver derive their cycle counts from the same rounding rule.
package ws2812b_pkg;

  typedef enum logic [1:0] {
    SYNC = 2'd0,
    IDLE = 2'd1,
    HIGH = 2'd2,
    LOW  = 2'd3
  } rx_state_t;

  localparam int CNT_W = 16;

  // Round-to-nearest of (num/den) * CLK_FREQ / LAT_FREQ, done in 64-bit integers.
  function automatic int scaled_cyc(input longint clk_freq, input longint lat_freq,
                                    input longint num, input longint den);
    longint q;
    q = (2 * clk_freq * num + lat_freq * den) / (2 * lat_freq * den);
    return int'(q);
  endfunction

  function automatic int bit_thresh_cyc(input longint clk_freq, input longint lat_freq);
    return scaled_cyc(clk_freq, lat_freq, 45, 100);
  endfunction

  function automatic int min_high_cyc(input longint clk_freq, input longint lat_freq);
    return scaled_cyc(clk_freq, lat_freq, 10, 100);
  endfunction

  function automatic int max_high_cyc(input longint clk_freq, input longint lat_freq);
    return scaled_cyc(clk_freq, lat_freq, 1, 1);
  endfunction

  function automatic int reset_det_cyc(input longint clk_freq, input longint lat_freq);
    return scaled_cyc(clk_freq, lat_freq, 40, 1);
  endfunction

  // Driver-side pulse widths; the low phase fills the rest of the bit period.
  function automatic int h0_cyc(input longint clk_freq, input longint lat_freq);
    return scaled_cyc(clk_freq, lat_freq, 25, 100);
  endfunction

  function automatic int h1_cyc(input longint clk_freq, input longint lat_freq);
    return scaled_cyc(clk_freq, lat_freq, 65, 100);
  endfunction

  function automatic int l0_cyc(input longint clk_freq, input longint lat_freq);
    return max_high_cyc(clk_freq, lat_freq) - h0_cyc(clk_freq, lat_freq);
  endfunction

  function automatic int l1_cyc(input longint clk_freq, input longint lat_freq);
    return max_high_cyc(clk_freq, lat_freq) - h1_cyc(clk_freq, lat_freq);
  endfunction

endpackage

// File: rtl/ws2812b_pulse_timer.sv
// Synchronises din, registers its edges and times the current level with a
// saturating counter that clears on each registered edge.
module ws2812b_pulse_timer
  import ws2812b_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             din,
  output logic             rise,
  output logic             fall,
  output logic             level,
  output logic [CNT_W-1:0] cnt
);

  logic meta_p0;
  logic sync_p1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      level   <= 1'b0;
      rise    <= 1'b0;
      fall    <= 1'b0;
      cnt     <= '0;
    end else begin
      // p0/p1: two-flop synchroniser
      meta_p0 <= din;
      sync_p1 <= meta_p0;
      // p2: edge register; cnt restarts once the edge is visible downstream
      level   <= sync_p1;
      rise    <= sync_p1 & ~level;
      fall    <= ~sync_p1 & level;
      if (rise || fall)
        cnt <= '0;
      else if (cnt != '1)
        cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/ws2812b_receiver.sv
// WS2812b line decoder: classifies high pulses into bits, assembles MSB-first
// words and reports word, frame-end and protocol-error events.
module ws2812b_receiver
  import ws2812b_pkg::*;
#(
  parameter int CLK_FREQ              = 50000000,
  parameter int LAT_FREQ              = 800000,
  parameter int LED_DATA_BUS_WIDTH    = 24,
  parameter int LED_ADDRESS_BUS_WIDTH = 24
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             din,
  output logic [LED_DATA_BUS_WIDTH-1:0]    data,
  output logic                             data_valid,
  output logic [LED_ADDRESS_BUS_WIDTH-1:0] led_index,
  output logic                             frame_done,
  output logic [LED_ADDRESS_BUS_WIDTH-1:0] led_count,
  output logic                             error,
  output logic                             busy
);

  localparam int BIT_THRESH_CYC = bit_thresh_cyc(CLK_FREQ, LAT_FREQ);
  localparam int MIN_HIGH_CYC   = min_high_cyc(CLK_FREQ, LAT_FREQ);
  localparam int MAX_HIGH_CYC   = max_high_cyc(CLK_FREQ, LAT_FREQ);
  localparam int RESET_DET_CYC  = reset_det_cyc(CLK_FREQ, LAT_FREQ);

  localparam logic [CNT_W-1:0] THRESH_C    = CNT_W'(BIT_THRESH_CYC);
  localparam logic [CNT_W-1:0] MIN_HIGH_C  = CNT_W'(MIN_HIGH_CYC);
  localparam logic [CNT_W-1:0] MAX_HIGH_C  = CNT_W'(MAX_HIGH_CYC);
  localparam logic [CNT_W-1:0] RESET_END_C = CNT_W'(RESET_DET_CYC - 1);

  localparam int BIT_W = $clog2(LED_DATA_BUS_WIDTH);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(LED_DATA_BUS_WIDTH - 1);

  logic             rise;
  logic             fall;
  logic             level;
  logic [CNT_W-1:0] cnt;

  ws2812b_pulse_timer u_timer (
    .clk   (clk),
    .reset (reset),
    .din   (din),
    .rise  (rise),
    .fall  (fall),
    .level (level),
    .cnt   (cnt)
  );

  rx_state_t                         state;
  logic [BIT_W-1:0]                  bit_cnt;
  logic [LED_DATA_BUS_WIDTH-1:0]     shreg;
  logic [LED_ADDRESS_BUS_WIDTH-1:0]  idx;
  logic                              word_pend;
  logic                              gap_end;
  logic                              cur_bit;
  logic                              err_now;
  logic                              emit_word;

  assign gap_end   = (cnt >= RESET_END_C);
  assign cur_bit   = (cnt >= THRESH_C);
  assign emit_word = word_pend && !err_now;
  assign busy      = (state == HIGH) || (state == LOW);

  // Any violation this cycle; it also suppresses a word pending in the same cycle.
  always_comb begin
    err_now = 1'b0;
    case (state)
      HIGH:    err_now = fall ? (cnt < MIN_HIGH_C) : (cnt > MAX_HIGH_C);
      LOW:     err_now = gap_end && (bit_cnt != '0);
      default: err_now = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= SYNC;
      bit_cnt    <= '0;
      shreg      <= '0;
      idx        <= '0;
      word_pend  <= 1'b0;
      data       <= '0;
      data_valid <= 1'b0;
      led_index  <= '0;
      frame_done <= 1'b0;
      led_count  <= '0;
      error      <= 1'b0;
    end else begin
      // output stage: publish the word completed on the previous cycle
      data_valid <= emit_word;
      error      <= err_now;
      frame_done <= 1'b0;
      word_pend  <= 1'b0;
      if (emit_word) begin
        data      <= shreg;
        led_index <= idx;
        if (idx != '1)
          idx <= idx + LED_ADDRESS_BUS_WIDTH'(1);
      end

      // decode stage
      case (state)
        SYNC: begin
          if (!level && gap_end)
            state <= IDLE;
        end
        IDLE: begin
          if (rise) begin
            state   <= HIGH;
            bit_cnt <= '0;
            idx     <= '0;
          end
        end
        HIGH: begin
          if (err_now) begin
            state <= SYNC;
          end else if (fall) begin
            shreg <= {shreg[LED_DATA_BUS_WIDTH-2:0], cur_bit};
            state <= LOW;
            if (bit_cnt == LAST_BIT) begin
              bit_cnt   <= '0;
              word_pend <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + BIT_W'(1);
            end
          end
        end
        LOW: begin
          if (gap_end) begin
            frame_done <= 1'b1;
            led_count  <= idx;
            bit_cnt    <= '0;
            // A rise landing exactly on the gap boundary opens the next frame.
            if (rise) begin
              state <= HIGH;
              idx   <= '0;
            end else begin
              state <= IDLE;
            end
          end else if (rise) begin
            state <= HIGH;
          end
        end
        default: state <= SYNC;
      endcase
    end
  end

endmodule

// File: tb/tb_ws2812b_receiver.sv
// Scoreboard bench for ws2812b_receiver: a frame-level line model predicts
// words, frame ends and errors; a monitor compares them as the DUT reports.
`timescale 1ns/1ps
module tb_ws2812b_receiver;

  localparam int H0 = 16, L0 = 47, H1 = 41, L1 = 22;
  localparam int GAP = 2800;
  localparam int GAP_MIN = 2700;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        din = 1'b0;
  logic [23:0] data;
  logic        data_valid;
  logic [23:0] led_index;
  logic        frame_done;
  logic [23:0] led_count;
  logic        error;
  logic        busy;

  ws2812b_receiver dut (
    .clk        (clk),
    .reset      (reset),
    .din        (din),
    .data       (data),
    .data_valid (data_valid),
    .led_index  (led_index),
    .frame_done (frame_done),
    .led_count  (led_count),
    .error      (error),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [23:0] d;
    logic [23:0] idx;
  } word_t;

  typedef struct {
    logic [23:0] cnt;
    logic        err;
  } frame_t;

  word_t  word_q[$];
  frame_t frame_q[$];
  int     err_q[$];

  // Line-level reference: what a well-behaved receiver should report.
  bit          m_synced = 1'b0;
  bit          m_busy = 1'b0;
  int          m_words = 0;
  int          m_bits = 0;
  logic [23:0] m_shift = '0;

  function automatic void model_clear();
    m_busy  = 1'b0;
    m_words = 0;
    m_bits  = 0;
  endfunction

  function automatic void model_bit(input bit b);
    word_t w;
    if (!m_synced) return;
    m_busy  = 1'b1;
    m_shift = {m_shift[22:0], b};
    m_bits++;
    if (m_bits == 24) begin
      w.d   = m_shift;
      w.idx = (m_words >= 24'hFFFFFF) ? 24'hFFFFFF : 24'(m_words);
      word_q.push_back(w);
      m_words++;
      m_bits = 0;
    end
  endfunction

  function automatic void model_gap(input int n);
    frame_t f;
    if (n < GAP_MIN) return;
    if (m_synced && m_busy) begin
      f.cnt = 24'(m_words);
      f.err = (m_bits != 0);
      frame_q.push_back(f);
    end
    m_synced = 1'b1;
    model_clear();
  endfunction

  function automatic void model_bad_pulse();
    if (m_synced) err_q.push_back(1);
    m_synced = 1'b0;
    model_clear();
  endfunction

  int fall_cyc = 0;
  int rise_cyc = 0;
  int dv_cyc = 0;
  int err_cyc = 0;
  int dv_cnt = 0;

  task automatic drive_bit(input bit b, input int h, input int l);
    model_bit(b);
    din = 1'b1;
    repeat (h) @(negedge clk);
    din = 1'b0;
    fall_cyc = cyc + 1;
    repeat (l) @(negedge clk);
  endtask

  task automatic send_word_std(input logic [23:0] w);
    for (int i = 23; i >= 0; i--)
      drive_bit(w[i], w[i] ? H1 : H0, w[i] ? L1 : L0);
  endtask

  task automatic send_bit_rand(input bit b);
    int h;
    int l;
    h = b ? int'($urandom_range(58, 32)) : int'($urandom_range(24, 8));
    l = int'($urandom_range(40, 12));
    if ($urandom_range(31, 0) == 0) l += int'($urandom_range(1200, 100));
    drive_bit(b, h, l);
  endtask

  task automatic gap(input int n);
    model_gap(n);
    din = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic bad_pulse(input int h);
    model_bad_pulse();
    din = 1'b1;
    rise_cyc = cyc + 1;
    repeat (h) @(negedge clk);
    din = 1'b0;
    repeat (40) @(negedge clk);
  endtask

  // Monitor: pops the scoreboard whenever the DUT raises an event.
  word_t  wexp;
  frame_t fexp;
  always @(negedge clk) begin
    if (!reset) begin
      if (data_valid) begin
        dv_cnt++;
        dv_cyc = cyc;
        check("error_with_word", 32'(error), 32'd0);
        if (word_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got data 0x%0h index %0d, expected no word", data, led_index);
        end else begin
          wexp = word_q.pop_front();
          check("word_data", 32'(data), 32'(wexp.d));
          check("word_index", 32'(led_index), 32'(wexp.idx));
        end
      end
      if (frame_done) begin
        if (frame_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame: got led_count %0d, expected no frame_done", led_count);
        end else begin
          fexp = frame_q.pop_front();
          check("frame_count", 32'(led_count), 32'(fexp.cnt));
          check("frame_error", 32'(error), 32'(fexp.err));
        end
      end else if (error) begin
        err_cyc = cyc;
        if (err_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_error: got error pulse at cycle %0d, expected none", cyc);
        end else begin
          void'(err_q.pop_front());
          check("busy_after_error", 32'(busy), 32'd0);
        end
      end
    end
  end

  initial begin
    logic [23:0] w;
    int nwords;
    int nextra;

    reset = 1'b1;
    din   = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_data", 32'(data), 32'd0);
    check("reset_valid", 32'(data_valid), 32'd0);
    check("reset_index", 32'(led_index), 32'd0);
    check("reset_count", 32'(led_count), 32'd0);
    check("reset_frame_done", 32'(frame_done), 32'd0);
    check("reset_error", 32'(error), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    reset = 1'b0;

    // Power-up sync, then a single word with driver timing.
    gap(3125);
    send_word_std(24'hA5C3F0);
    check("busy_in_frame", 32'(busy), 32'd1);
    gap(3125);
    check("word_latency", 32'(dv_cyc - fall_cyc), 32'd4);
    check("single_word_count", 32'(dv_cnt), 32'd1);
    check("busy_after_frame", 32'(busy), 32'd0);

    // Three back-to-back words.
    send_word_std(24'hFF0000);
    send_word_std(24'h00FF00);
    send_word_std(24'h0000FF);
    gap(GAP);
    check("three_word_count", 32'(dv_cnt), 32'd4);

    // Ten bits then a gap: partial-word error.
    for (int i = 0; i < 10; i++) drive_bit(i[0], i[0] ? H1 : H0, i[0] ? L1 : L0);
    gap(GAP);
    check("partial_no_word", 32'(dv_cnt), 32'd4);

    // Short glitch, an ignored word, resync, then a decodable word.
    bad_pulse(3);
    send_word_std(24'h5A5A5A);
    gap(GAP);
    check("ignored_after_glitch", 32'(dv_cnt), 32'd4);
    send_word_std(24'h3C3C3C);
    gap(GAP);

    // Stuck-high line.
    bad_pulse(100);
    check("stuck_err_timing", 32'((err_cyc - rise_cyc >= 60) && (err_cyc - rise_cyc <= 70)), 32'd1);
    gap(GAP);

    // Reset in the middle of a word.
    for (int i = 0; i < 12; i++) drive_bit(i[1], i[1] ? H1 : H0, i[1] ? L1 : L0);
    reset = 1'b1;
    m_synced = 1'b0;
    model_clear();
    #1;
    check("midreset_data", 32'(data), 32'd0);
    check("midreset_index", 32'(led_index), 32'd0);
    check("midreset_count", 32'(led_count), 32'd0);
    check("midreset_busy", 32'(busy), 32'd0);
    check("midreset_valid", 32'(data_valid), 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    gap(GAP);
    send_word_std(24'h123456);
    gap(GAP);

    // Randomised frames, some ending on a partial word.
    for (int f = 0; f < 4; f++) begin
      nwords = int'($urandom_range(3, 1));
      nextra = ($urandom_range(3, 0) == 0) ? int'($urandom_range(23, 1)) : 0;
      for (int k = 0; k < nwords; k++) begin
        w = 24'($urandom);
        for (int i = 23; i >= 0; i--) send_bit_rand(w[i]);
      end
      for (int i = 0; i < nextra; i++) send_bit_rand(1'($urandom));
      gap(GAP);
    end

    check("words_left", 32'(word_q.size()), 32'd0);
    check("frames_left", 32'(frame_q.size()), 32'd0);
    check("errors_left", 32'(err_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
